md_unit: RTL and testbench
==========================

# md_unit

Multi-cycle multiply/divide unit with HI/LO registers, the parametrised sequential companion to the single-cycle ALU in the execute stage. Accepts one operation per start pulse, holds `busy` for a fixed, op-dependent number of cycles, then commits results to HI/LO. Also supports one-cycle MTHI/MTLO writes. The pipeline control stalls on `busy`, and on any new md op while `busy`.

## Interface
- `WIDTH`, 32: operand and HI/LO width; must be ≥ 2.
- `MULT_CYCLES`, 5: busy duration for MULT/MULTU; must be ≥ 1.
- `DIV_CYCLES`, 10: busy duration for DIV/DIVU; must be ≥ 1.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: sample `mdop`, `a`, `b` this edge.
- `mdop` in 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6–7 no-op.
- `a` in WIDTH: rs operand.
- `b` in WIDTH: rt operand.
- `busy` out 1: operation in flight.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.
- `done` out 1: one-cycle pulse in the cycle HI/LO first shows a mult/div result.

## Operation
- Idle (`busy`=0) + `start` + mult/div op:
  - Compute the result from `a`/`b` at the sample edge into shadow registers.
  - Load the counter with `MULT_CYCLES` or `DIV_CYCLES`; set `busy`=1.
  - HI/LO keep their old values until commit.
- Running: the counter decrements each edge. On the edge where counter==1: HI/LO take the shadow values, `busy`→0, `done`→1 for one cycle.
- MTHI/MTLO with `start` while idle: HI (or LO) = `a` at that edge. No busy, no `done`, the other register unchanged.
- `start` while `busy`=1 (any op, including MTHI/MTLO): ignored entirely, no state change. The pipeline must not issue it; the bench checks it is ignored.
- `start` with `mdop` 6–7: no-op.
- MULT: signed 2·WIDTH product; HI = upper WIDTH bits, LO = lower. MULTU: same, unsigned.
- DIV: signed, truncating toward zero; LO = quotient, HI = remainder with the sign of the dividend. DIVU: unsigned.
- Divide by zero (DIV/DIVU): LO = all ones, HI = `a`. Busy duration unchanged.
- Signed overflow (DIV, `a` = −2^(WIDTH−1), `b` = −1): LO = −2^(WIDTH−1), HI = 0.
- `reset`: HI=0, LO=0, `busy`=0, `done`=0, counter=0, shadow registers cleared.
  - Reset mid-operation discards the pending result and returns to idle the next cycle.
  - Reset has priority over `start` on the same edge.

## Timing
- Mult/div sampled at edge E:
  - `busy`=1 in cycles E+1 … E+N (N = the op's cycle count).
  - HI/LO show the new values from edge E+N onward.
  - `busy`=0 and `done`=1 in the cycle after edge E+N.
- Back-to-back: a new `start` is accepted at edge E+N+1, i.e. in the first cycle `busy` is low.
- MTHI/MTLO sampled at edge E: the new value is visible after edge E. `busy` stays 0.
- `hi`/`lo`/`busy`/`done` are all register outputs, with no combinational path from inputs.
- Reset values of all outputs: 0.

## Structure
- Package `md_pkg`: `mdop` encodings (`MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`, `MD_MTHI`, `MD_MTLO`) as localparam constants, plus the op-width constant, shared with the decoder and hazard unit.
- Sub-module `md_calc`: purely combinational WIDTH-parametrised result computation (signed/unsigned product, quotient and remainder, div-by-zero and overflow rules). Outputs `{hi_next, lo_next}`.
- `md_unit` owns the counter, busy/done control, shadow registers and HI/LO.

## Test plan
- Reset, then MULT a=0xFFFFFFFE (−2), b=3 → `busy` high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA, `done` pulses once.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001 after 5 cycles.
- DIV a=−7, b=2 → after 10 busy cycles lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). DIVU a=7, b=0 → lo=0xFFFFFFFF, hi=7.
- DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0. During this op, MTHI a=0x1234 with `start` in busy cycle 3 → ignored, hi=0 at commit.
- MTLO a=0xDEADBEEF when idle → lo=0xDEADBEEF next cycle, `busy` stays 0, hi unchanged.
- MULT started, `reset` asserted in busy cycle 2 → next cycle hi=lo=0, `busy`=0, no `done`. A `start` together with `reset` on the same edge is ignored.

Source files
------------

// File: rtl/md_pkg.sv
// md_pkg
// Shared definitions for the multiply/divide unit. The decoder and hazard unit
// use the same package so that all blocks agree on the mdop encodings.
//   MD_OP_W        : width of the mdop field
//   MD_MULT..MD_MTLO : mdop encodings (6 and 7 are no-ops)
//   isMultDiv()    : true for ops that take the multi-cycle path
//   isMult()       : true for MULT/MULTU (selects the shorter busy time)
package md_pkg;

  localparam int MD_OP_W = 3;

  localparam logic [MD_OP_W-1:0] MD_MULT  = 3'd0;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 3'd1;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 3'd2;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'd3;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'd4;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'd5;

  function automatic logic isMultDiv(input logic [MD_OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic isMult(input logic [MD_OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/md_calc.sv
// md_calc
// Purely combinational result generator for the multiply/divide unit.
// Produces the value that HI/LO will take once the operation commits.
//   i_op     : mdop (only MULT/MULTU/DIV/DIVU produce a result, others give 0)
//   i_a      : rs operand (multiplicand / dividend)
//   i_b      : rt operand (multiplier / divisor)
//   o_result : {hi_next, lo_next}
module md_calc
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [MD_OP_W-1:0]  i_op,
  input  logic [WIDTH-1:0]    i_a,
  input  logic [WIDTH-1:0]    i_b,
  output logic [2*WIDTH-1:0]  o_result
);

  // Both products are formed as 2W x 2W truncated to 2W; for the signed case
  // the operands are sign-extended first, which yields the exact signed product.
  logic [2*WIDTH-1:0] w_aSext;
  logic [2*WIDTH-1:0] w_bSext;
  logic [2*WIDTH-1:0] w_aZext;
  logic [2*WIDTH-1:0] w_bZext;
  logic [2*WIDTH-1:0] w_sProd;
  logic [2*WIDTH-1:0] w_uProd;

  assign w_aSext = {{WIDTH{i_a[WIDTH-1]}}, i_a};
  assign w_bSext = {{WIDTH{i_b[WIDTH-1]}}, i_b};
  assign w_aZext = {{WIDTH{1'b0}}, i_a};
  assign w_bZext = {{WIDTH{1'b0}}, i_b};
  assign w_sProd = w_aSext * w_bSext;
  assign w_uProd = w_aZext * w_bZext;

  // Signed division is done on magnitudes and the signs fixed afterwards:
  // the quotient is negative when the operand signs differ, the remainder
  // takes the dividend's sign. The overflow case (most negative / -1) falls
  // out naturally: magnitude 2^(W-1) / 1 gives 2^(W-1), remainder 0.
  logic             w_divSigned;
  logic             w_aNeg;
  logic             w_bNeg;
  logic [WIDTH-1:0] w_aMag;
  logic [WIDTH-1:0] w_bMag;
  logic [WIDTH-1:0] w_uQuot;
  logic [WIDTH-1:0] w_uRem;
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_rem;

  assign w_divSigned = (i_op == MD_DIV);
  assign w_aNeg      = w_divSigned & i_a[WIDTH-1];
  assign w_bNeg      = w_divSigned & i_b[WIDTH-1];
  assign w_aMag      = w_aNeg ? (-i_a) : i_a;
  assign w_bMag      = w_bNeg ? (-i_b) : i_b;
  assign w_uQuot     = w_aMag / w_bMag;
  assign w_uRem      = w_aMag % w_bMag;
  assign w_quot      = (w_aNeg ^ w_bNeg) ? (-w_uQuot) : w_uQuot;
  assign w_rem       = w_aNeg ? (-w_uRem) : w_uRem;

  // Divide by zero bypasses the divider entirely: LO all ones, HI = dividend.
  always_comb begin
    o_result = '0;
    case (i_op)
      MD_MULT:  o_result = w_sProd;
      MD_MULTU: o_result = w_uProd;
      MD_DIV, MD_DIVU: begin
        if (i_b == '0) begin
          o_result = {i_a, {WIDTH{1'b1}}};
        end else begin
          o_result = {w_rem, w_quot};
        end
      end
      default:  o_result = '0;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// md_unit
// Multi-cycle multiply/divide unit with HI/LO registers. The result is
// computed when the operation is accepted and parked in shadow registers;
// a down-counter models the op latency and HI/LO are updated at the end.
//   i_clk    : clock, rising edge
//   i_reset  : synchronous active-high reset
//   i_start  : accept i_mdop/i_a/i_b this edge (ignored while busy)
//   i_mdop   : operation (see md_pkg)
//   i_a/i_b  : rs/rt operands
//   o_busy   : mult/div in flight
//   o_hi/o_lo: HI/LO registers
//   o_done   : one-cycle pulse when HI/LO first show a mult/div result
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [MD_OP_W-1:0] i_mdop,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_busy,
  output logic [WIDTH-1:0]   o_hi,
  output logic [WIDTH-1:0]   o_lo,
  output logic               o_done
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [2*WIDTH-1:0] w_result;

  logic [CNT_W-1:0]   r_count;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_shadowHi;
  logic [WIDTH-1:0]   r_shadowLo;

  md_calc #(
    .WIDTH (WIDTH)
  ) u_calc (
    .i_op     (i_mdop),
    .i_a      (i_a),
    .i_b      (i_b),
    .o_result (w_result)
  );

  // The counter is loaded with N at the accepting edge and commits on the
  // edge where it reads 1, so busy is high for exactly N cycles. While busy,
  // every start is dropped, including MTHI/MTLO.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_shadowHi <= '0;
      r_shadowLo <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_busy) begin
        if (r_count == CNT_W'(1)) begin
          r_hi    <= r_shadowHi;
          r_lo    <= r_shadowLo;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_count <= '0;
        end else begin
          r_count <= r_count - CNT_W'(1);
        end
      end else if (i_start) begin
        if (isMultDiv(i_mdop)) begin
          r_shadowHi <= w_result[2*WIDTH-1:WIDTH];
          r_shadowLo <= w_result[WIDTH-1:0];
          r_count    <= isMult(i_mdop) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
          r_busy     <= 1'b1;
        end else if (i_mdop == MD_MTHI) begin
          r_hi <= i_a;
        end else if (i_mdop == MD_MTLO) begin
          r_lo <= i_a;
        end
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit
// Directed bench for md_unit: multiply/divide results, busy length, done
// pulse, divide-by-zero and overflow, MTHI/MTLO, ignored starts and reset.
module tb_md_unit;
  import md_pkg::*;

  logic               clk;
  logic               reset;
  logic               start;
  logic [MD_OP_W-1:0] mdop;
  logic [31:0]        a;
  logic [31:0]        b;
  logic               busy;
  logic [31:0]        hi;
  logic [31:0]        lo;
  logic               done;

  int testsRun;
  int testsFailed;

  md_unit #(
    .WIDTH       (32),
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .i_start (start),
    .i_mdop  (mdop),
    .i_a     (a),
    .i_b     (b),
    .o_busy  (busy),
    .o_hi    (hi),
    .o_lo    (lo),
    .o_done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one observed value against its expected value and logs mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Called at a falling edge: presents one start for exactly one rising edge
  // and returns at the following falling edge.
  task automatic applyStimulus(input logic [MD_OP_W-1:0] op,
                               input logic [31:0] opA, input logic [31:0] opB);
    start = 1'b1;
    mdop  = op;
    a     = opA;
    b     = opB;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Issues a mult/div, checks HI/LO hold during busy, the busy length, that
  // done stays low while busy and pulses in the first idle cycle, and the result.
  // Returns in that first idle cycle so the next op can start back-to-back.
  task automatic runOp(input string tag, input logic [MD_OP_W-1:0] op,
                       input logic [31:0] opA, input logic [31:0] opB,
                       input int expCycles, input logic [31:0] expHi,
                       input logic [31:0] expLo);
    logic [31:0] preHi;
    logic [31:0] preLo;
    int cycles;
    int doneSeen;
    preHi = hi;
    preLo = lo;
    applyStimulus(op, opA, opB);
    checkOutput({tag, "_holdHi"}, hi, preHi);
    checkOutput({tag, "_holdLo"}, lo, preLo);
    cycles   = 0;
    doneSeen = 0;
    while (busy === 1'b1 && cycles < 40) begin
      cycles++;
      if (done !== 1'b0) doneSeen++;
      @(negedge clk);
    end
    checkOutput({tag, "_busyCycles"}, cycles, expCycles);
    checkOutput({tag, "_doneWhileBusy"}, doneSeen, 0);
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd1);
    checkOutput({tag, "_hi"}, hi, expHi);
    checkOutput({tag, "_lo"}, lo, expLo);
  endtask

  initial begin
    int cycles;
    int seen;
    logic [31:0] preHi;

    testsRun    = 0;
    testsFailed = 0;
    reset = 1'b1;
    start = 1'b0;
    mdop  = '0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_hi",   hi, 32'h0);
    checkOutput("rst_lo",   lo, 32'h0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    runOp("mult_neg", MD_MULT, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
    @(negedge clk);
    checkOutput("mult_donePulse", {31'd0, done}, 32'd0);

    // Each op below starts in the done cycle of the previous one.
    runOp("multu_max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFE, 32'h00000001);
    runOp("div_m7_2",  MD_DIV,   32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    runOp("divu_by0",  MD_DIVU,  32'd7,        32'd0,        10, 32'h00000007, 32'hFFFFFFFF);
    runOp("div_7_m2",  MD_DIV,   32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD);
    runOp("div_by0",   MD_DIV,   32'hFFFFFFF9, 32'd0,        10, 32'hFFFFFFF9, 32'hFFFFFFFF);
    runOp("divu_big",  MD_DIVU,  32'hFFFFFFFF, 32'd16,       10, 32'h0000000F, 32'h0FFFFFFF);
    runOp("mult_min",  MD_MULT,  32'h80000000, 32'h80000000, 5, 32'h40000000, 32'h00000000);
    @(negedge clk);

    // Overflow divide with an MTHI presented in busy cycle 3 that must be dropped.
    preHi = hi;
    applyStimulus(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
    cycles = 0;
    while (busy === 1'b1 && cycles < 40) begin
      if (cycles == 2) begin
        start = 1'b1;
        mdop  = MD_MTHI;
        a     = 32'h00001234;
      end else begin
        start = 1'b0;
      end
      if (cycles == 3) checkOutput("ovf_mthiIgnored", hi, preHi);
      cycles++;
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput("ovf_busyCycles", cycles, 10);
    checkOutput("ovf_done", {31'd0, done}, 32'd1);
    checkOutput("ovf_hi", hi, 32'h00000000);
    checkOutput("ovf_lo", lo, 32'h80000000);
    @(negedge clk);

    applyStimulus(MD_MTHI, 32'hCAFEF00D, 32'h0);
    checkOutput("mthi_hi",   hi, 32'hCAFEF00D);
    checkOutput("mthi_lo",   lo, 32'h80000000);
    checkOutput("mthi_busy", {31'd0, busy}, 32'd0);

    applyStimulus(MD_MTLO, 32'hDEADBEEF, 32'h0);
    checkOutput("mtlo_lo",   lo, 32'hDEADBEEF);
    checkOutput("mtlo_hi",   hi, 32'hCAFEF00D);
    checkOutput("mtlo_busy", {31'd0, busy}, 32'd0);
    checkOutput("mtlo_done", {31'd0, done}, 32'd0);

    applyStimulus(3'd6, 32'h11111111, 32'h22222222);
    checkOutput("nop_hi",   hi, 32'hCAFEF00D);
    checkOutput("nop_lo",   lo, 32'hDEADBEEF);
    checkOutput("nop_busy", {31'd0, busy}, 32'd0);

    // Reset in busy cycle 2, with a competing MTLO start on the same edge.
    applyStimulus(MD_MULT, 32'd5, 32'd7);
    checkOutput("rstmid_busy1", {31'd0, busy}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    mdop  = MD_MTLO;
    a     = 32'h00005555;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    checkOutput("rstmid_hi",   hi, 32'h0);
    checkOutput("rstmid_lo",   lo, 32'h0);
    checkOutput("rstmid_busy", {31'd0, busy}, 32'd0);
    checkOutput("rstmid_done", {31'd0, done}, 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) seen++;
    end
    checkOutput("rstmid_quiet", seen, 0);
    checkOutput("rstmid_loAfter", lo, 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
